// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the two-to-one instruction/data memory bus arbiter.
package ibex_mem_arb_pkg;

  typedef enum logic {
    ArbSrcInstr = 1'b0,
    ArbSrcData  = 1'b1
  } arb_src_e;

  localparam logic [3:0] InstrBe = 4'hF;

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// Outstanding-transaction ID FIFO: records which port issued each granted
// request so in-order responses can be steered back to it.
module ibex_mem_arb_id_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push,
  input  arb_src_e push_src,
  input  logic     pop,
  output arb_src_e head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_src_e            storage [Depth];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [CntW-1:0]     count;

  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);
  assign head  = storage[rd_ptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; head is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) storage[wr_ptr] <= push_src;
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the
// instruction-fetch and load/store ports, with responses routed by issue order.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        ResetDataFirst = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  arb_src_e sel;
  arb_src_e last_src;
  arb_src_e locked_src;
  arb_src_e head;
  logic     locked;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fire;
  logic     resp_valid;

  // NOTE: sel gets a default first so no path through this block infers a latch.
  always_comb begin
    sel = ArbSrcInstr;
    if (locked) begin
      sel = locked_src;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_src == ArbSrcInstr) ? ArbSrcData : ArbSrcInstr;
    end else if (data_req_i) begin
      sel = ArbSrcData;
    end
  end

  // Full blocks the request outright, independent of any same-cycle pop.
  assign mem_req_o   = !rst_i && !fifo_full && (instr_req_i || data_req_i);
  assign fire        = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = fire && (sel == ArbSrcInstr);
  assign data_gnt_o  = fire && (sel == ArbSrcData);

  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = InstrBe;
    mem_wdata_o = '0;
    if (sel == ArbSrcData) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // An ungranted request pins the source so the bus attributes stay stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked     <= 1'b0;
      locked_src <= ArbSrcInstr;
      last_src   <= ResetDataFirst ? ArbSrcInstr : ArbSrcData;
    end else begin
      if (mem_req_o) begin
        locked     <= !mem_gnt_i;
        locked_src <= sel;
      end
      if (fire) last_src <= sel;
    end
  end

  assign resp_valid = mem_rvalid_i && !fifo_empty;

  ibex_mem_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (fire),
    .push_src (sel),
    .pop      (resp_valid),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign instr_rvalid_o = resp_valid && (head == ArbSrcInstr);
  assign data_rvalid_o  = resp_valid && (head == ArbSrcData);
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: doc/ibex_mem_arbiter.md
# ibex_mem_arbiter
Two-to-one bus arbiter that lets the core's instruction-fetch and load/store ports share one single-ported memory bus. It sits between the core's instr_*/data_* ports and a single memory port using the same req/gnt/rvalid protocol. The block arbitrates round-robin, holds its choice stable while a request is pending, and routes each in-order response back to its issuer through an outstanding-ID FIFO.
## Interface
- MaxOutstanding, 2: maximum granted-but-unanswered transactions (≥1, power of two).
- ResetDataFirst, 1'b1: 1 = data port wins the first contested arbitration after reset.
- clk_i  in  1  clock; all state rises on this edge.
- rst_i  in  1  reset, asynchronous, active-high; clears all state.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  fetch request accepted.
- instr_addr_i  in  32  fetch address.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- instr_err_o  out  1  fetch bus error.
- data_req_i  in  1  load/store request.
- data_gnt_o  out  1  load/store accepted.
- data_we_i  in  1  store enable.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  load/store address.
- data_wdata_i  in  32  store data.
- data_rvalid_o  out  1  load/store response valid.
- data_rdata_o  out  32  load data.
- data_err_o  out  1  load/store bus error.
- mem_req_o  out  1  shared-bus request.
- mem_gnt_i  in  1  shared-bus grant.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  address.
- mem_wdata_o  out  32  write data.
- mem_rvalid_i  in  1  response valid, in issue order.
- mem_rdata_i  in  32  response data.
- mem_err_i  in  1  response error.
## Operation
- Selection: when nothing is locked and the FIFO is not full, the sole requester is chosen. If both request, the port not granted last is chosen (last_src register).
- Lock: if mem_req_o=1 and mem_gnt_i=0, register locked=1 and locked_src=selected. Next cycles keep the same source until the grant, even if the other port requests. This keeps the OBI address/attributes stable. The lock clears on the grant.
- Instruction transactions drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0. Data transactions pass data_* through unchanged.
- Grant: instr_gnt_o = mem_gnt_i & mem_req_o & (src==instr). data_gnt_o is the same with src==data. On a grant, push src into the ID FIFO and set last_src=src.
- Response: on mem_rvalid_i, pop the FIFO head and raise the matching *_rvalid_o/_err_o with mem_rdata_i. The other port's rvalid is 0.
- rdata_o is mem_rdata_i on both ports at all times; consumers qualify it with rvalid.
- FIFO full (count==MaxOutstanding): mem_req_o=0 and both grants are 0. This holds even when a pop happens the same cycle, so there is no rvalid→req combinational path.
- Push and pop in the same cycle: count is unchanged and the pointers advance and wrap modulo MaxOutstanding.
- mem_rvalid_i with an empty FIFO: the response is dropped and no rvalid is forwarded.
## Timing
- Reset values: mem_req_o=0; all gnt/rvalid/err outputs=0; count=0; locked=0; last_src=instr if ResetDataFirst else data.
- Zero-cycle request and grant paths: mem_req_o combinationally follows instr_req_i|data_req_i when not full.
- Response routing is zero-cycle: rvalid and err are decoded from the FIFO head in the same cycle. No added latency, so full throughput is one transaction per cycle.
- Reset mid-transaction flushes the FIFO. Responses to pre-reset grants are then dropped as spurious.
## Structure
- Shared package ibex_mem_arb_pkg holds the typedef arb_src_e (ArbSrcInstr=1'b0, ArbSrcData=1'b1).
- Sub-module ibex_mem_arb_id_fifo implements the outstanding-ID FIFO: a parameterised-depth, 1-bit-wide FIFO with push/pop, full/empty flags and a head output.
## Test plan
- Instruction fetch only, addr 0x100, mem_gnt_i=1 every cycle → instr_gnt_o in the same cycle, mem_we_o=0, mem_be_o=4'hF. An rvalid with rdata 0x00000013 reaches instr_rvalid_o only.
- Both ports request every cycle with gnt=1, reset default → grants alternate data, instr, data, instr. Responses return to their issuers in order.
- Instruction request pending with gnt=0 for 3 cycles, then data_req_i rises → mem_addr_o stays at the instruction address until the grant. The data request is granted the cycle after.
- MaxOutstanding=2, two grants with no rvalid → mem_req_o=0 in the third cycle. One rvalid in the fourth cycle → mem_req_o returns the following cycle.
- Store, addr 0x200, data 0xDEADBEEF, be 4'b0011, response with mem_err_i=1 → mem_* fields match the store. data_err_o=1 and instr_err_o=0.
- rst_i pulsed with 2 outstanding, then 2 stray rvalids → no rvalid forwarded; count=0.
